// File: rtl/ula_display_pkg.sv
// Shared types, seven-segment codes and BCD helper for the ALU result display stage.
package ula_display_pkg;

  localparam int DISP_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } disp_state_t;

  // Active-low segment patterns, bit6..bit0 = g..a
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
    if (nib >= 4'd5) begin
      add3_if_ge5 = nib + 4'd3;
    end else begin
      add3_if_ge5 = nib;
    end
  endfunction

endpackage

// File: rtl/ula_display_if.sv
// Result/display bundle between the ALU side (master) and the display stage (slave).
interface ula_display_if
  import ula_display_pkg::*;
  #(parameter int W = DISP_W);

  logic         res_valid;
  logic [W-1:0] res;
  logic         res_zero;
  logic         res_ovf;
  logic         signed_mode;
  logic         busy;
  logic         done;
  logic [6:0]   HEX0;
  logic [6:0]   HEX1;
  logic [6:0]   HEX2;
  logic [6:0]   HEX3;
  logic         led_zero;
  logic         led_ovf;

  modport master (
    output res_valid, res, res_zero, res_ovf, signed_mode,
    input  busy, done, HEX0, HEX1, HEX2, HEX3, led_zero, led_ovf
  );

  modport slave (
    input  res_valid, res, res_zero, res_ovf, signed_mode,
    output busy, done, HEX0, HEX1, HEX2, HEX3, led_zero, led_ovf
  );

endinterface

// File: rtl/ula_display_hex7seg.sv
// Combinational BCD digit to active-low seven-segment pattern, with forced blank.
module hex7seg
  import ula_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Digit decode; non-BCD codes blank the digit
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/ula_display.sv
// Captures one ALU result, converts its magnitude to two BCD digits by sequential
// double-dabble, then updates the four seven-segment digits and the flag LEDs.
module ula_display
  import ula_display_pkg::*;
  #(parameter int W = DISP_W)
(
  input  logic          CLOCK_50,
  input  logic          reset,
  ula_display_if.slave  bus
);

  localparam int CW = $clog2(W + 1);

  disp_state_t   r_state;
  disp_state_t   w_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_mag;
  logic [7:0]    r_bcd;
  logic          r_neg;
  logic          r_zero;
  logic          r_ovf;
  logic          r_done;
  logic          r_led_zero;
  logic          r_led_ovf;
  logic [6:0]    r_hex0;
  logic [6:0]    r_hex1;
  logic [6:0]    r_hex2;
  logic [6:0]    r_hex3;

  logic          w_accept;
  logic          w_neg;
  logic [W-1:0]  w_mag;
  logic [7:0]    w_bcd_adj;
  logic [6:0]    w_seg0;
  logic [6:0]    w_seg1;

  // Two's-complement negation is mod 2^W, so the most negative value maps to 2^(W-1)
  assign w_accept  = (r_state == IDLE) && bus.res_valid;
  assign w_neg     = bus.signed_mode & bus.res[W-1];
  assign w_mag     = w_neg ? (~bus.res + {{(W-1){1'b0}}, 1'b1}) : bus.res;
  assign w_bcd_adj = {add3_if_ge5(r_bcd[7:4]), add3_if_ge5(r_bcd[3:0])};

  hex7seg u_units (
    .i_bcd   (r_bcd[3:0]),
    .i_blank (1'b0),
    .o_seg   (w_seg0)
  );

  hex7seg u_tens (
    .i_bcd   (r_bcd[7:4]),
    .i_blank (r_bcd[7:4] == 4'd0),
    .o_seg   (w_seg1)
  );

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.res_valid) begin
          w_next = SHIFT;
        end else begin
          w_next = IDLE;
        end
      end
      SHIFT: begin
        if (r_cnt == CW'(1)) begin
          w_next = UPDATE;
        end else begin
          w_next = SHIFT;
        end
      end
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture, shift-add-3 datapath and display registers
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_mag      <= '0;
      r_bcd      <= 8'd0;
      r_neg      <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_led_zero <= 1'b0;
      r_led_ovf  <= 1'b0;
      r_hex0     <= SEG_BLANK;
      r_hex1     <= SEG_BLANK;
      r_hex2     <= SEG_BLANK;
      r_hex3     <= SEG_BLANK;
    end else begin
      r_done <= (r_state == UPDATE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_neg  <= w_neg;
            r_zero <= bus.res_zero;
            r_ovf  <= bus.res_ovf;
            r_mag  <= w_mag;
            r_bcd  <= 8'd0;
            r_cnt  <= CW'(W);
          end
        end
        SHIFT: begin
          {r_bcd, r_mag} <= {w_bcd_adj[6:0], r_mag, 1'b0};
          r_cnt          <= r_cnt - CW'(1);
        end
        UPDATE: begin
          r_hex0     <= w_seg0;
          r_hex1     <= w_seg1;
          r_hex2     <= r_neg ? SEG_MINUS : SEG_BLANK;
          r_hex3     <= r_ovf ? SEG_E : SEG_BLANK;
          r_led_zero <= r_zero;
          r_led_ovf  <= r_ovf;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
  assign bus.HEX0     = r_hex0;
  assign bus.HEX1     = r_hex1;
  assign bus.HEX2     = r_hex2;
  assign bus.HEX3     = r_hex3;
  assign bus.led_zero = r_led_zero;
  assign bus.led_ovf  = r_led_ovf;

endmodule

// File: tb/tb_ula_display.sv
// Self-checking bench for ula_display: cycle-level reference model plus directed literal checks.
module tb_ula_display;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  ula_display_if #(.W(6)) bus ();

  ula_display #(.W(6)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model: an accepted result appears on the displays 7 edges later
  int         cyc   = 0;
  int         acc_k = -100;
  int         m_mag;
  logic       m_neg;
  logic [6:0] p_h0, p_h1, p_h2, p_h3;
  logic       p_z, p_o;
  logic [6:0] e_h0 = 7'h7F, e_h1 = 7'h7F, e_h2 = 7'h7F, e_h3 = 7'h7F;
  logic       e_z = 1'b0, e_o = 1'b0;

  always @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      acc_k = -100;
      e_h0 = 7'h7F; e_h1 = 7'h7F; e_h2 = 7'h7F; e_h3 = 7'h7F;
      e_z = 1'b0; e_o = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (cyc == acc_k + 7) begin
        e_h0 = p_h0; e_h1 = p_h1; e_h2 = p_h2; e_h3 = p_h3;
        e_z = p_z; e_o = p_o;
      end
      if (bus.res_valid === 1'b1 && cyc >= acc_k + 8) begin
        acc_k = cyc;
        m_neg = bus.signed_mode && (int'(bus.res) >= 32);
        m_mag = m_neg ? 64 - int'(bus.res) : int'(bus.res);
        p_h0  = seg_tab[m_mag % 10];
        p_h1  = (m_mag / 10 == 0) ? 7'h7F : seg_tab[m_mag / 10];
        p_h2  = m_neg ? 7'h3F : 7'h7F;
        p_h3  = bus.res_ovf ? 7'h06 : 7'h7F;
        p_z   = bus.res_zero;
        p_o   = bus.res_ovf;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic offer(input logic [5:0] r, input logic sm, input logic z, input logic o);
    @(negedge CLOCK_50);
    bus.res = r; bus.signed_mode = sm; bus.res_zero = z; bus.res_ovf = o;
    bus.res_valid = 1'b1;
    @(negedge CLOCK_50);
    bus.res_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int t = 0; t < 20; t++) begin
      if (bus.done === 1'b1) return;
      if (bus.busy === 1'b1) n++;
      @(negedge CLOCK_50);
    end
    checks++;
    failures++;
    $display("FAIL done_timeout actual=no_done expected=done_within_20_cycles");
  endtask

  int n;

  initial begin
    bus.res_valid = 1'b0; bus.res = 6'd0; bus.res_zero = 1'b0;
    bus.res_ovf = 1'b0; bus.signed_mode = 1'b0;
    #1 reset = 1'b0;

    fork
      forever begin
        @(negedge CLOCK_50);
        chk("m_busy", bus.busy, (cyc >= acc_k) && (cyc < acc_k + 7));
        chk("m_done", bus.done, cyc == acc_k + 7);
        chk("m_hex0", bus.HEX0, e_h0);
        chk("m_hex1", bus.HEX1, e_h1);
        chk("m_hex2", bus.HEX2, e_h2);
        chk("m_hex3", bus.HEX3, e_h3);
        chk("m_led_zero", bus.led_zero, e_z);
        chk("m_led_ovf", bus.led_ovf, e_o);
      end
    join_none

    // Valid offered while reset is held must be ignored
    repeat (2) @(negedge CLOCK_50);
    offer(6'd45, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    chk("rst_hex0", bus.HEX0, 7'h7F);
    chk("rst_hex3", bus.HEX3, 7'h7F);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_leds", {bus.led_zero, bus.led_ovf}, 2'b00);
    @(negedge CLOCK_50);
    reset = 1'b1;

    offer(6'd45, 1'b0, 1'b0, 1'b0);
    wait_done(n);
    chk("u45_busy_cycles", n, 7);
    chk("u45_hex1", bus.HEX1, 7'h19);
    chk("u45_hex0", bus.HEX0, 7'h12);
    chk("u45_hex23", {bus.HEX2, bus.HEX3}, {7'h7F, 7'h7F});

    offer(6'b100000, 1'b1, 1'b0, 1'b0);
    wait_done(n);
    chk("s32_hex", {bus.HEX2, bus.HEX1, bus.HEX0}, {7'h3F, 7'h30, 7'h24});

    offer(6'b100000, 1'b0, 1'b0, 1'b0);
    wait_done(n);
    chk("u32_hex", {bus.HEX2, bus.HEX1, bus.HEX0}, {7'h7F, 7'h30, 7'h24});

    offer(6'd0, 1'b0, 1'b1, 1'b0);
    wait_done(n);
    chk("z_hex", {bus.HEX1, bus.HEX0}, {7'h7F, 7'h40});
    chk("z_led_zero", bus.led_zero, 1'b1);

    offer(6'd63, 1'b0, 1'b0, 1'b1);
    wait_done(n);
    chk("o63_hex", {bus.HEX3, bus.HEX1, bus.HEX0}, {7'h06, 7'h02, 7'h30});
    chk("o63_leds", {bus.led_zero, bus.led_ovf}, 2'b01);

    // 7 accepted at k; 9 at k+3 and k+7 dropped; 9 at k+8 accepted
    for (int i = 0; i < 9; i++) begin
      @(negedge CLOCK_50);
      if (i == 8) begin
        chk("drop_done", bus.done, 1'b1);
        chk("drop_hex0_7", bus.HEX0, 7'h78);
      end
      bus.res_valid = (i == 0) || (i == 3) || (i == 7) || (i == 8);
      bus.res = (i == 0) ? 6'd7 : 6'd9;
      bus.signed_mode = 1'b0; bus.res_zero = 1'b0; bus.res_ovf = 1'b0;
    end
    @(negedge CLOCK_50);
    bus.res_valid = 1'b0;
    wait_done(n);
    chk("drop_hex0_9", bus.HEX0, 7'h10);

    // Reset mid-conversion aborts immediately with no done pulse
    offer(6'd21, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge CLOCK_50);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_hex", {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}, {4{7'h7F}});
    chk("abort_leds", {bus.led_zero, bus.led_ovf}, 2'b00);
    repeat (3) begin
      @(negedge CLOCK_50);
      chk("abort_no_done", bus.done, 1'b0);
    end
    reset = 1'b1;
    offer(6'd21, 1'b0, 1'b0, 1'b0);
    wait_done(n);
    chk("post_abort_busy_cycles", n, 7);
    chk("post_abort_hex", {bus.HEX1, bus.HEX0}, {7'h24, 7'h79});

    repeat (3) @(negedge CLOCK_50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
